// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel strobe/tone generator.
package tick_gen_pkg;

  localparam int unsigned CLK_HZ    = 100_000_000;
  localparam int unsigned DIV_250HZ = 400_000;
  localparam int unsigned DIV_1MHZ  = 100;
  localparam int unsigned DEF_CNT_W = 32;

  // Divide value that yields the requested strobe rate from the system clock.
  function automatic int unsigned hz_to_div(input int unsigned hz);
    return CLK_HZ / hz;
  endfunction

endpackage

// File: rtl/tick_ch.sv
// One strobe/square channel: programmable divide, phase-reset on load,
// freeze on disable.
module tick_ch
  import tick_gen_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned DEF_DIV = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div,
  output logic             tick,
  output logic             sq
);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;

  // Next-state: load restarts the phase, enable advances the count, else hold.
  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    sq_d    = sq_q;
    // Wrap back to 1 rather than 0 so a tick lands on the wrapping edge.
    cnt_inc = (cnt_q >= div_q) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    if (load) begin
      div_d = div;
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (en) begin
      cnt_d  = cnt_inc;
      tick_d = (cnt_inc == CNT_W'(1));
      if (tick_d) begin
        sq_d = ~sq_q;
      end
    end
  end

  // State register with synchronous reset to the default divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= CNT_W'(DEF_DIV);
      cnt_q  <= '0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel strobe/tone generator: config write decode and validation,
// with one tick_ch per channel.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned DEF_DIV = 100,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic              cfg_err
);

  // One extra bit so NUM_CH itself is representable for the range check.
  localparam logic [CH_W:0] NumChW = NUM_CH[CH_W:0];

  logic              cfg_ok;
  logic [NUM_CH-1:0] load;
  logic              cfg_err_q, cfg_err_d;

  // Validate the write and decode it to a one-hot per-channel load.
  always_comb begin
    cfg_ok    = ({1'b0, cfg_ch} < NumChW) && (cfg_div != '0);
    cfg_err_d = cfg_we && !cfg_ok;
    load      = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      load[i] = cfg_we && cfg_ok && (cfg_ch == CH_W'(i));
    end
  end

  // Rejected-write pulse, registered so it appears the cycle after the write.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    tick_ch #(
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV)
    ) u_ch (
      .clk (clk_100M),
      .rst (rst),
      .en  (ch_en[g]),
      .load(load[g]),
      .div (cfg_div),
      .tick(tick[g]),
      .sq  (sq[g])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi: directed scenarios plus random
// traffic, all checked every cycle against an edge-count reference model.
module tb_tick_gen_multi;

  localparam int unsigned NUM_CH  = 5;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned DEF_DIV = 100;
  localparam int unsigned CH_W    = 3;

  logic              clk_100M = 1'b0;
  logic              rst      = 1'b1;
  logic              cfg_we   = 1'b0;
  logic [CH_W-1:0]   cfg_ch   = '0;
  logic [CNT_W-1:0]  cfg_div  = '0;
  logic [NUM_CH-1:0] ch_en    = '0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic              cfg_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_on = 1'b0;

  // Reference model: per channel, divide value and enabled edges since reload.
  longint unsigned   m_div [NUM_CH];
  longint unsigned   m_e   [NUM_CH];
  logic [NUM_CH-1:0] exp_tick;
  logic [NUM_CH-1:0] exp_sq;
  logic              exp_err;

  tick_gen_multi #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .DEF_DIV(DEF_DIV)
  ) dut (
    .clk_100M(clk_100M),
    .rst     (rst),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .ch_en   (ch_en),
    .tick    (tick),
    .sq      (sq),
    .cfg_err (cfg_err)
  );

  always #5 clk_100M = ~clk_100M;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tick count after e enabled edges is ceil(e/div); a tick falls on edges
  // 1, 1+div, 1+2*div, ... and the square is the parity of the tick count.
  task automatic model_edge();
    bit ok;
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        m_div[i] = DEF_DIV;
        m_e[i]   = 0;
      end
      exp_tick = '0;
      exp_sq   = '0;
      exp_err  = 1'b0;
      return;
    end
    ok      = (int'(cfg_ch) < int'(NUM_CH)) && (cfg_div != 0);
    exp_err = cfg_we && !ok;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (cfg_we && ok && int'(cfg_ch) == i) begin
        m_div[i]    = cfg_div;
        m_e[i]      = 0;
        exp_tick[i] = 1'b0;
        exp_sq[i]   = 1'b0;
      end else if (ch_en[i]) begin
        m_e[i]++;
        exp_tick[i] = ((m_e[i] - 1) % m_div[i]) == 0;
        exp_sq[i]   = ((((m_e[i] - 1) / m_div[i]) + 1) % 2) == 1;
      end else begin
        exp_tick[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk_100M);
    model_edge();
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk_100M) begin
    if (check_on) begin
      check("tick", 64'(tick), 64'(exp_tick));
      check("sq", 64'(sq), 64'(exp_sq));
      check("cfg_err", 64'(cfg_err), 64'(exp_err));
    end
  end

  initial begin
    // Reset.
    rst = 1'b1;
    step();
    check_on = 1'b1;
    check("reset_tick", 64'(tick), 64'h0);
    check("reset_sq", 64'(sq), 64'h0);
    check("reset_err", 64'(cfg_err), 64'h0);

    // 1: all channels at the default divide.
    rst   = 1'b0;
    ch_en = '1;
    step();
    check("t1_first_tick", 64'(tick), 64'h1f);
    check("t1_first_sq", 64'(sq), 64'h1f);
    step();
    check("t1_tick_low", 64'(tick), 64'h0);
    steps(98);
    check("t1_edge100_tick", 64'(tick), 64'h0);
    check("t1_edge100_sq", 64'(sq), 64'h1f);
    step();
    check("t1_edge101_tick", 64'(tick), 64'h1f);
    check("t1_edge101_sq", 64'(sq), 64'h0);
    steps(20);

    // 2: reprogram ch1 mid-count.
    cfg_we  = 1'b1;
    cfg_ch  = 3'd1;
    cfg_div = 32'd3;
    step();
    cfg_we = 1'b0;
    check("t2_ch1_tick", 64'(tick[1]), 64'h0);
    check("t2_ch1_sq", 64'(sq[1]), 64'h0);
    step();
    check("t2_ch1_first", 64'(tick[1]), 64'h1);
    steps(3);
    check("t2_ch1_second", 64'(tick[1]), 64'h1);
    steps(40);

    // 3: rejected writes (zero divide, out-of-range channel).
    cfg_we  = 1'b1;
    cfg_ch  = 3'd0;
    cfg_div = 32'd0;
    step();
    cfg_we = 1'b0;
    check("t3_err_div0", 64'(cfg_err), 64'h1);
    step();
    check("t3_err_clear", 64'(cfg_err), 64'h0);
    cfg_we  = 1'b1;
    cfg_ch  = 3'(NUM_CH);
    cfg_div = 32'd7;
    step();
    cfg_we = 1'b0;
    check("t3_err_ch", 64'(cfg_err), 64'h1);
    steps(30);

    // 4: freeze ch2 for 37 cycles at cnt=50 after a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(50);
    ch_en[2] = 1'b0;
    for (int k = 0; k < 37; k++) begin
      step();
      check("t4_gap_tick", 64'(tick[2]), 64'h0);
    end
    ch_en[2] = 1'b1;
    steps(50);
    check("t4_before_tick", 64'(tick[2]), 64'h0);
    step();
    check("t4_resume_tick", 64'(tick[2]), 64'h1);
    steps(10);

    // 5: divide of 1 on ch3.
    cfg_we  = 1'b1;
    cfg_ch  = 3'd3;
    cfg_div = 32'd1;
    step();
    cfg_we = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("t5_tick_high", 64'(tick[3]), 64'h1);
      check("t5_sq_toggle", 64'(sq[3]), 64'(k % 2));
    end

    // 6: reset wins over a simultaneous write.
    rst     = 1'b1;
    cfg_we  = 1'b1;
    cfg_ch  = 3'd0;
    cfg_div = 32'd2;
    step();
    rst    = 1'b0;
    cfg_we = 1'b0;
    check("t6_tick", 64'(tick), 64'h0);
    check("t6_sq", 64'(sq), 64'h0);
    check("t6_err", 64'(cfg_err), 64'h0);
    steps(3);
    check("t6_ch0_default", 64'(tick[0]), 64'h0);

    // Random traffic against the model.
    for (int k = 0; k < 6000; k++) begin
      rst    = ($urandom_range(0, 999) == 0);
      cfg_we = ($urandom_range(0, 15) == 0);
      cfg_ch = 3'($urandom_range(0, 7));
      cfg_div = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 9));
      for (int i = 0; i < int'(NUM_CH); i++) begin
        ch_en[i] = ($urandom_range(0, 7) != 0);
      end
      step();
    end
    cfg_we = 1'b0;
    step();

    @(posedge clk_100M);
    check_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
